// File: rtl/baud_gen_frac.sv
// Fractional baud-rate tick generator: emits an oversample tick every
// int+frac/2^F cycles on average and a bit tick every OVS oversample ticks.
module baud_gen_frac #(
    parameter int unsigned N        = 16,
    parameter int unsigned F        = 4,
    parameter int unsigned OVS      = 16,
    parameter int unsigned DEF_INT  = 27,
    parameter int unsigned DEF_FRAC = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         sync_clr,
    input  logic         div_wr,
    input  logic [N-1:0] div_int,
    input  logic [F-1:0] div_frac,
    output logic         os_tick,
    output logic         bit_tick,
    output logic         div_pend,
    output logic [N-1:0] q
);

    localparam int unsigned OS_W = $clog2(OVS);
    localparam logic [N-1:0]    CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0]    CNT_ONE  = N'(1'b1);
    localparam logic [OS_W-1:0] OS_ZERO  = {OS_W{1'b0}};
    localparam logic [OS_W-1:0] OS_ONE   = OS_W'(1'b1);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVS - 1);
    localparam logic [F-1:0]    ACC_ZERO = {F{1'b0}};

    // One fractional step: returns {carry, acc + frac}
    function automatic logic [F:0] frac_step(input logic [F-1:0] acc, input logic [F-1:0] frac);
        frac_step = {1'b0, acc} + {1'b0, frac};
    endfunction

    logic [N-1:0]    cnt_r, cnt_nxt_s;
    logic [OS_W-1:0] os_cnt_r, os_cnt_nxt_s;
    logic [F-1:0]    acc_r, acc_nxt_s;
    logic            extra_r, extra_nxt_s;
    logic [N-1:0]    act_int_r, act_int_nxt_s;
    logic [F-1:0]    act_frac_r, act_frac_nxt_s;
    logic [N-1:0]    pend_int_r, pend_int_nxt_s;
    logic [F-1:0]    pend_frac_r, pend_frac_nxt_s;
    logic            pend_valid_r, pend_valid_nxt_s;
    logic            os_tick_r, os_tick_nxt_s;
    logic            bit_tick_r, bit_tick_nxt_s;
    logic [N-1:0]    eff_int_s;
    logic [N-1:0]    last_s;
    logic [F:0]      sum_s;

    // Period end value; a zero divisor behaves as one
    always_comb begin
        eff_int_s = (act_int_r == CNT_ZERO) ? CNT_ONE : act_int_r;
        last_s    = eff_int_s - CNT_ONE + N'(extra_r);
        sum_s     = frac_step(acc_r, act_frac_r);
    end

    // Next-state logic: sync_clr beats wrap/count, which beats hold
    always_comb begin
        cnt_nxt_s        = cnt_r;
        os_cnt_nxt_s     = os_cnt_r;
        acc_nxt_s        = acc_r;
        extra_nxt_s      = extra_r;
        act_int_nxt_s    = act_int_r;
        act_frac_nxt_s   = act_frac_r;
        pend_int_nxt_s   = pend_int_r;
        pend_frac_nxt_s  = pend_frac_r;
        pend_valid_nxt_s = pend_valid_r;
        os_tick_nxt_s    = 1'b0;
        bit_tick_nxt_s   = 1'b0;

        if (sync_clr) begin
            cnt_nxt_s    = CNT_ZERO;
            os_cnt_nxt_s = OS_ZERO;
            acc_nxt_s    = ACC_ZERO;
            extra_nxt_s  = 1'b0;
            if (div_wr) begin
                act_int_nxt_s    = div_int;
                act_frac_nxt_s   = div_frac;
                pend_valid_nxt_s = 1'b0;
            end else if (pend_valid_r) begin
                act_int_nxt_s    = pend_int_r;
                act_frac_nxt_s   = pend_frac_r;
                pend_valid_nxt_s = 1'b0;
            end else begin
                pend_valid_nxt_s = pend_valid_r;
            end
        end else if (en) begin
            if (cnt_r == last_s) begin
                cnt_nxt_s      = CNT_ZERO;
                os_tick_nxt_s  = 1'b1;
                bit_tick_nxt_s = (os_cnt_r == OS_LAST);
                os_cnt_nxt_s   = (os_cnt_r == OS_LAST) ? OS_ZERO : os_cnt_r + OS_ONE;
                if (div_wr) begin
                    // A write landing on the boundary waits a full period; older pending is dropped
                    pend_int_nxt_s   = div_int;
                    pend_frac_nxt_s  = div_frac;
                    pend_valid_nxt_s = 1'b1;
                    acc_nxt_s        = sum_s[F-1:0];
                    extra_nxt_s      = sum_s[F];
                end else if (pend_valid_r) begin
                    act_int_nxt_s    = pend_int_r;
                    act_frac_nxt_s   = pend_frac_r;
                    pend_valid_nxt_s = 1'b0;
                    acc_nxt_s        = ACC_ZERO;
                    extra_nxt_s      = 1'b0;
                end else begin
                    acc_nxt_s   = sum_s[F-1:0];
                    extra_nxt_s = sum_s[F];
                end
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
                if (div_wr) begin
                    pend_int_nxt_s   = div_int;
                    pend_frac_nxt_s  = div_frac;
                    pend_valid_nxt_s = 1'b1;
                end else begin
                    pend_valid_nxt_s = pend_valid_r;
                end
            end
        end else begin
            if (div_wr) begin
                act_int_nxt_s  = div_int;
                act_frac_nxt_s = div_frac;
                cnt_nxt_s      = CNT_ZERO;
                os_cnt_nxt_s   = OS_ZERO;
                acc_nxt_s      = ACC_ZERO;
                extra_nxt_s    = 1'b0;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end
    end

    // State and tick registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= CNT_ZERO;
            os_cnt_r     <= OS_ZERO;
            acc_r        <= ACC_ZERO;
            extra_r      <= 1'b0;
            act_int_r    <= N'(DEF_INT);
            act_frac_r   <= F'(DEF_FRAC);
            pend_int_r   <= CNT_ZERO;
            pend_frac_r  <= ACC_ZERO;
            pend_valid_r <= 1'b0;
            os_tick_r    <= 1'b0;
            bit_tick_r   <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            os_cnt_r     <= os_cnt_nxt_s;
            acc_r        <= acc_nxt_s;
            extra_r      <= extra_nxt_s;
            act_int_r    <= act_int_nxt_s;
            act_frac_r   <= act_frac_nxt_s;
            pend_int_r   <= pend_int_nxt_s;
            pend_frac_r  <= pend_frac_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            os_tick_r    <= os_tick_nxt_s;
            bit_tick_r   <= bit_tick_nxt_s;
        end
    end

    assign os_tick  = os_tick_r;
    assign bit_tick = bit_tick_r;
    assign div_pend = pend_valid_r;
    assign q        = cnt_r;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed and randomized bench for baud_gen_frac; tick times are predicted
// from the closed form T_k = (k+1)*I + floor(k*frac/2^F).
module tb_baud_gen_frac;

    localparam int N   = 16;
    localparam int F   = 4;
    localparam int OVS = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         sync_clr;
    logic         div_wr;
    logic [N-1:0] div_int;
    logic [F-1:0] div_frac;
    logic         os_tick;
    logic         bit_tick;
    logic         div_pend;
    logic [N-1:0] q;

    int tests = 0;
    int fails = 0;
    int tick17_t;

    baud_gen_frac #(.N(N), .F(F), .OVS(OVS), .DEF_INT(27), .DEF_FRAC(0)) dut (
        .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .div_wr(div_wr),
        .div_int(div_int), .div_frac(div_frac), .os_tick(os_tick), .bit_tick(bit_tick),
        .div_pend(div_pend), .q(q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic load_idle(input int i_val, input int f_val);
        en       = 1'b0;
        div_wr   = 1'b1;
        div_int  = N'(i_val);
        div_frac = F'(f_val);
        step();
        div_wr   = 1'b0;
    endtask

    // Steps until os_tick is seen; n = edges taken, -1 if the limit expires
    task automatic wait_tick(output int n, input int limit);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (os_tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Reference: from a fresh phase (cnt=0, os_cnt=0, acc=0), the k-th tick
    // lands after T_k enabled edges; q is enabled edges since the last tick.
    task automatic run_model(input int i_val, input int f_val, input int ncyc, input bit rand_en);
        int ie;
        int t;
        int k;
        int next_t;
        int last_t;
        bit e;
        bit exp_os;
        bit exp_bit;
        ie       = (i_val == 0) ? 1 : i_val;
        t        = 0;
        k        = 0;
        next_t   = ie;
        last_t   = 0;
        tick17_t = -1;
        for (int n = 0; n < ncyc; n++) begin
            e  = rand_en ? ($urandom_range(7) != 0) : 1'b1;
            en = e;
            step();
            exp_os  = 1'b0;
            exp_bit = 1'b0;
            if (e) begin
                t++;
                if (t == next_t) begin
                    exp_os = 1'b1;
                    k++;
                    last_t  = t;
                    next_t  = (k + 1) * ie + ((k * f_val) >> F);
                    exp_bit = ((k % OVS) == 0);
                    if (k == 17) tick17_t = t;
                end
            end
            check("os_tick", int'(os_tick), int'(exp_os));
            check("bit_tick", int'(bit_tick), int'(exp_bit));
            check("q", int'(q), t - last_t);
            check("div_pend_idle", int'(div_pend), 0);
        end
        en = 1'b0;
    endtask

    initial begin
        int  n;
        bit  ok;
        int  ri;
        int  rf;

        reset    = 1'b0;
        en       = 1'b0;
        sync_clr = 1'b0;
        div_wr   = 1'b0;
        div_int  = '0;
        div_frac = '0;

        // Reset values
        do_reset();
        check("rst_os_tick", int'(os_tick), 0);
        check("rst_bit_tick", int'(bit_tick), 0);
        check("rst_div_pend", int'(div_pend), 0);
        check("rst_q", int'(q), 0);

        // Integer division with the reset divisor
        run_model(27, 0, 440, 1'b0);

        // Fractional division 27 + 8/16
        load_idle(27, 8);
        run_model(27, 8, 480, 1'b0);
        check("frac_17_periods", tick17_t, 467);

        // Pending divisor written mid-period
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pend_q5", int'(q), 5);
        div_wr  = 1'b1;
        div_int = N'(10);
        div_frac = F'(0);
        step();
        div_wr = 1'b0;
        check("pend_set", int'(div_pend), 1);
        for (int i = 0; i < 15; i++) step();
        check("pend_held", int'(div_pend), 1);
        wait_tick(n, 40);
        check("pend_old_period_rest", n, 6);
        check("pend_cleared", int'(div_pend), 0);
        wait_tick(n, 40);
        check("pend_new_period1", n, 10);
        wait_tick(n, 40);
        check("pend_new_period2", n, 10);

        // Phase clear at cnt=13, os_cnt=7
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 7 * 27 + 13; i++) step();
        check("clr_pre_q", int'(q), 13);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check("clr_q", int'(q), 0);
        check("clr_os_tick", int'(os_tick), 0);
        run_model(27, 0, 450, 1'b0);

        // Enable gating at cnt=20
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("gate_q20", int'(q), 20);
        en = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (q !== N'(20) || os_tick !== 1'b0 || bit_tick !== 1'b0) ok = 1'b0;
        end
        check("gate_hold", int'(ok), 1);
        en = 1'b1;
        wait_tick(n, 40);
        check("gate_resume", n, 7);

        // Divisor 0 acts as 1: tick every cycle
        load_idle(0, 0);
        en = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (os_tick !== 1'b1) ok = 1'b0;
        end
        check("div0_continuous", int'(ok), 1);

        // Reset mid-count restores defaults
        do_reset();
        check("mid_rst_os_tick", int'(os_tick), 0);
        check("mid_rst_bit_tick", int'(bit_tick), 0);
        check("mid_rst_div_pend", int'(div_pend), 0);
        check("mid_rst_q", int'(q), 0);
        run_model(27, 0, 60, 1'b0);

        // Randomized divisors with random enable gaps
        for (int it = 0; it < 6; it++) begin
            ri = $urandom_range(0, 40);
            rf = $urandom_range(0, 15);
            load_idle(ri, rf);
            run_model(ri, rf, $urandom_range(150, 500), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
